// File: rtl/keypad_entry_pkg.sv
// Shared types and constants for the keypad entry block and its consumers.
package keypad_pkg;

  localparam int CODE_W = 5;
  localparam logic [CODE_W-1:0] BLANK = 5'd31;
  localparam logic [4*CODE_W-1:0] BUF_BLANK = 20'hFFFFF;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  // Position of the single set bit; callers only rely on it for one-hot input.
  function automatic logic [1:0] onehot_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    case (v)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_entry_if.sv
// Keypad pins plus the digit-buffer outputs that feed the 7-segment driver.
interface keypad_entry_if;
  import keypad_pkg::*;

  logic [3:0]          row;
  logic                clr;
  logic [3:0]          col;
  logic [4*CODE_W-1:0] num;
  logic [CODE_W-1:0]   key_code;
  logic                key_valid;

  modport master (
    input  row,
    input  clr,
    output col,
    output num,
    output key_code,
    output key_valid
  );

  modport slave (
    output row,
    output clr,
    input  col,
    input  num,
    input  key_code,
    input  key_valid
  );

endinterface

// File: rtl/keypad_entry_scan_tick.sv
// Free-running divider producing a one-clk tick every DIV cycles.
module scan_tick #(
  parameter int DIV = 25000
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = w_last;

endmodule

// File: rtl/keypad_entry.sv
// Scans a 4x4 hex keypad, debounces one key at a time and shifts each
// accepted code into a four-digit buffer in the display driver's encoding.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 25000,
  parameter int DEBOUNCE = 4
) (
  input logic           clk,
  input logic           rst_n,
  keypad_entry_if.master bus
);

  // Wide enough to hold DEBOUNCE+1, which RELEASE can reach when DEBOUNCE=1.
  localparam int DEB_W = $clog2(DEBOUNCE + 2);
  localparam logic [DEB_W-1:0] DEB_TARGET = DEB_W'(DEBOUNCE);
  localparam logic [DEB_W-1:0] DEB_ONE    = DEB_W'(1);

  logic                w_tick;
  logic [3:0]          r_sync1;
  logic [3:0]          r_sync2;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [3:0]          r_col;
  logic [3:0]          w_col_nxt;
  logic [DEB_W-1:0]    r_deb_cnt;
  logic [DEB_W-1:0]    w_deb_nxt;
  logic [3:0]          r_pattern;
  logic [3:0]          w_pattern_nxt;
  logic [3:0]          r_code;
  logic [3:0]          w_code_nxt;

  logic                w_accept;
  logic [3:0]          w_accept_code;

  logic [4*CODE_W-1:0] r_num;
  logic [CODE_W-1:0]   r_key_code;
  logic                r_key_valid;

  logic [3:0]          w_low;
  logic                w_all_high;
  logic                w_one_low;
  logic [3:0]          w_scan_code;
  logic [3:0]          w_col_rot;
  logic [DEB_W-1:0]    w_deb_inc;

  scan_tick #(
    .DIV (SCAN_DIV)
  ) u_scan_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_tick (w_tick)
  );

  // Rows come straight off the keypad pins and are asynchronous to clk.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 4'b1111;
      r_sync2 <= 4'b1111;
    end else begin
      r_sync1 <= bus.row;
      r_sync2 <= r_sync1;
    end
  end

  assign w_low       = ~r_sync2;
  assign w_all_high  = &r_sync2;
  assign w_one_low   = (w_low != 4'd0) && ((w_low & (w_low - 4'd1)) == 4'd0);
  assign w_scan_code = {onehot_index(w_low), onehot_index(~r_col)};
  assign w_col_rot   = {r_col[2:0], r_col[3]};
  assign w_deb_inc   = r_deb_cnt + 1'b1;

  always_comb begin
    w_state_nxt   = r_state;
    w_col_nxt     = r_col;
    w_deb_nxt     = r_deb_cnt;
    w_pattern_nxt = r_pattern;
    w_code_nxt    = r_code;
    w_accept      = 1'b0;
    w_accept_code = r_code;

    if (w_tick) begin
      case (r_state)
        ST_SCAN: begin
          // Multi-row presses are treated like bounce and simply skipped.
          if (w_one_low) begin
            w_pattern_nxt = r_sync2;
            w_code_nxt    = w_scan_code;
            w_deb_nxt     = DEB_ONE;
            if (DEBOUNCE <= 1) begin
              w_accept      = 1'b1;
              w_accept_code = w_scan_code;
              w_state_nxt   = ST_HELD;
            end else begin
              w_state_nxt   = ST_DEBOUNCE;
            end
          end else begin
            w_col_nxt = w_col_rot;
          end
        end

        ST_DEBOUNCE: begin
          if (r_sync2 == r_pattern) begin
            w_deb_nxt = w_deb_inc;
            if (w_deb_inc >= DEB_TARGET) begin
              w_accept    = 1'b1;
              w_state_nxt = ST_HELD;
            end
          end else begin
            w_col_nxt   = w_col_rot;
            w_state_nxt = ST_SCAN;
          end
        end

        ST_HELD: begin
          if (w_all_high) begin
            w_deb_nxt   = DEB_ONE;
            w_state_nxt = ST_RELEASE;
          end
        end

        ST_RELEASE: begin
          if (w_all_high) begin
            w_deb_nxt = w_deb_inc;
            if (w_deb_inc >= DEB_TARGET) begin
              w_col_nxt   = w_col_rot;
              w_state_nxt = ST_SCAN;
            end
          end else begin
            w_state_nxt = ST_HELD;
          end
        end

        default: begin
          w_state_nxt = ST_SCAN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_SCAN;
      r_col     <= 4'b1110;
      r_deb_cnt <= '0;
      r_pattern <= 4'b1111;
      r_code    <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_col     <= w_col_nxt;
      r_deb_cnt <= w_deb_nxt;
      r_pattern <= w_pattern_nxt;
      r_code    <= w_code_nxt;
    end
  end

  // A clear on the accepting edge still lets key_valid/key_code report the key.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_num       <= BUF_BLANK;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
    end else begin
      r_key_valid <= w_accept;
      if (w_accept) begin
        r_key_code <= {1'b0, w_accept_code};
      end
      if (bus.clr) begin
        r_num <= BUF_BLANK;
      end else if (w_accept) begin
        r_num <= {r_num[3*CODE_W-1:0], 1'b0, w_accept_code};
      end
    end
  end

  assign bus.col       = r_col;
  assign bus.num       = r_num;
  assign bus.key_code  = r_key_code;
  assign bus.key_valid = r_key_valid;

endmodule

// File: tb/tb_keypad_entry.sv
// Self-checking bench for keypad_entry: a keypad matrix model drives the rows
// and a digit-list model predicts the buffer contents.
module tb_keypad_entry;
  import keypad_pkg::*;

  localparam int SCAN_DIV     = 4;
  localparam int DEB          = 2;
  localparam int PRESS_BOUND  = 2 + 4 * SCAN_DIV + (DEB - 1) * SCAN_DIV + 2;
  localparam int RELEASE_WAIT = 6 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pressed = 16'h0000;
  logic [3:0]  glitch_mask = 4'hF;

  int errors = 0;
  int checks = 0;
  int pulse_count = 0;
  int double_pulse = 0;
  logic prev_valid = 1'b0;

  logic [4:0] m_dig [4];

  keypad_entry_if bus ();

  keypad_entry #(
    .SCAN_DIV (SCAN_DIV),
    .DEBOUNCE (DEB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Matrix model: a pressed key pulls its row low while its column is driven.
  always_comb begin
    bus.row = glitch_mask;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[4*r + c] && !bus.col[c]) bus.row[r] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.key_valid) begin
      pulse_count <= pulse_count + 1;
      if (prev_valid) double_pulse <= double_pulse + 1;
    end
    prev_valid <= bus.key_valid;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) m_dig[i] = BLANK;
  endfunction

  function automatic void model_push(input int code);
    for (int i = 3; i > 0; i--) m_dig[i] = m_dig[i-1];
    m_dig[0] = 5'(code);
  endfunction

  function automatic logic [19:0] model_num();
    return {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
  endfunction

  task automatic press_wait(input int code, output logic got);
    pressed[code] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < PRESS_BOUND; i++) begin
      @(negedge clk);
      if (bus.key_valid) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic release_all();
    pressed = 16'h0000;
    repeat (RELEASE_WAIT) @(negedge clk);
  endtask

  task automatic test_reset();
    int p0;
    logic [3:0] exp_col;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    checks++;
    if (bus.col !== 4'b1110) begin
      errors++; $display("[TB] FAIL reset_col: got %b expected 1110", bus.col);
    end
    checks++;
    if (bus.num !== BUF_BLANK) begin
      errors++; $display("[TB] FAIL reset_num: got %h expected %h", bus.num, BUF_BLANK);
    end
    checks++;
    if (bus.key_code !== 5'd0 || bus.key_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_key: got code %0d valid %b expected 0 0", bus.key_code, bus.key_valid);
    end
    p0 = pulse_count;
    for (int k = 0; k < 40; k++) begin
      exp_col = ~(4'b0001 << ((k / SCAN_DIV) % 4));
      checks++;
      if (bus.col !== exp_col) begin
        errors++; $display("[TB] FAIL idle_col k=%0d: got %b expected %b", k, bus.col, exp_col);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (pulse_count != p0) begin
      errors++; $display("[TB] FAIL idle_pulses: got %0d expected 0", pulse_count - p0);
    end
    checks++;
    if (bus.num !== BUF_BLANK) begin
      errors++; $display("[TB] FAIL idle_num: got %h expected %h", bus.num, BUF_BLANK);
    end
  endtask

  task automatic test_single_key();
    int p0;
    logic got;
    p0 = pulse_count;
    press_wait(9, got);
    model_push(9);
    checks++;
    if (!got) begin
      errors++; $display("[TB] FAIL single_timeout: got no key_valid within %0d clk, expected a pulse", PRESS_BOUND);
    end
    checks++;
    if (bus.key_code !== 5'd9) begin
      errors++; $display("[TB] FAIL single_code: got %0d expected 9", bus.key_code);
    end
    checks++;
    if (bus.num !== model_num()) begin
      errors++; $display("[TB] FAIL single_num: got %h expected %h", bus.num, model_num());
    end
    repeat (100) @(negedge clk);
    #1;
    checks++;
    if (pulse_count - p0 != 1) begin
      errors++; $display("[TB] FAIL held_pulses: got %0d expected 1", pulse_count - p0);
    end
    release_all();
  endtask

  task automatic test_sequence();
    logic got;
    for (int code = 1; code <= 5; code++) begin
      press_wait(code, got);
      model_push(code);
      checks++;
      if (!got || bus.key_code !== 5'(code)) begin
        errors++; $display("[TB] FAIL seq_code %0d: got valid %b code %0d expected 1 %0d", code, got, bus.key_code, code);
      end
      repeat ($urandom_range(0, 12)) @(negedge clk);
      release_all();
    end
    checks++;
    if (bus.num !== model_num()) begin
      errors++; $display("[TB] FAIL seq_num: got %h expected %h", bus.num, model_num());
    end
  endtask

  task automatic test_random_keys();
    int p0;
    int code;
    logic got;
    p0 = pulse_count;
    for (int n = 0; n < 8; n++) begin
      code = int'($urandom_range(0, 15));
      press_wait(code, got);
      model_push(code);
      checks++;
      if (!got || bus.key_code !== 5'(code)) begin
        errors++; $display("[TB] FAIL rand_code %0d: got valid %b code %0d expected 1 %0d", n, got, bus.key_code, code);
      end
      checks++;
      if (bus.num !== model_num()) begin
        errors++; $display("[TB] FAIL rand_num %0d: got %h expected %h", n, bus.num, model_num());
      end
      repeat ($urandom_range(0, 20)) @(negedge clk);
      release_all();
    end
    #1;
    checks++;
    if (pulse_count - p0 != 8) begin
      errors++; $display("[TB] FAIL rand_pulses: got %0d expected 8", pulse_count - p0);
    end
  endtask

  task automatic test_glitch();
    int p0;
    int changes;
    logic [3:0] last_col;
    p0 = pulse_count;
    glitch_mask = 4'b1011;
    repeat (SCAN_DIV) @(negedge clk);
    glitch_mask = 4'hF;
    repeat (3 * SCAN_DIV) @(negedge clk);
    changes = 0;
    last_col = bus.col;
    for (int i = 0; i < 6 * SCAN_DIV; i++) begin
      @(negedge clk);
      if (bus.col !== last_col) changes++;
      last_col = bus.col;
    end
    #1;
    checks++;
    if (pulse_count != p0) begin
      errors++; $display("[TB] FAIL glitch_pulses: got %0d expected 0", pulse_count - p0);
    end
    checks++;
    if (changes < 3) begin
      errors++; $display("[TB] FAIL glitch_rotate: got %0d col changes expected at least 3", changes);
    end
    checks++;
    if (bus.num !== model_num()) begin
      errors++; $display("[TB] FAIL glitch_num: got %h expected %h", bus.num, model_num());
    end
  endtask

  task automatic test_two_rows();
    int p0;
    int c;
    p0 = pulse_count;
    c = int'($urandom_range(0, 3));
    pressed[c] = 1'b1;
    pressed[4 + c] = 1'b1;
    repeat (60) @(negedge clk);
    #1;
    checks++;
    if (pulse_count != p0) begin
      errors++; $display("[TB] FAIL two_rows_pulses col %0d: got %0d expected 0", c, pulse_count - p0);
    end
    release_all();
  endtask

  task automatic test_clr();
    logic got;
    int code;
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    model_clear();
    checks++;
    if (bus.num !== BUF_BLANK) begin
      errors++; $display("[TB] FAIL clr_num: got %h expected %h", bus.num, BUF_BLANK);
    end
    code = int'($urandom_range(0, 15));
    bus.clr = 1'b1;
    press_wait(code, got);
    checks++;
    if (!got || bus.key_code !== 5'(code)) begin
      errors++; $display("[TB] FAIL clr_accept_key: got valid %b code %0d expected 1 %0d", got, bus.key_code, code);
    end
    checks++;
    if (bus.num !== BUF_BLANK) begin
      errors++; $display("[TB] FAIL clr_accept_num: got %h expected %h", bus.num, BUF_BLANK);
    end
    bus.clr = 1'b0;
    release_all();
    code = int'($urandom_range(0, 15));
    press_wait(code, got);
    model_push(code);
    checks++;
    if (!got || bus.num !== model_num()) begin
      errors++; $display("[TB] FAIL after_clr_num: got valid %b num %h expected 1 %h", got, bus.num, model_num());
    end
    release_all();
  endtask

  task automatic test_reset_held();
    logic got;
    press_wait(9, got);
    model_push(9);
    checks++;
    if (!got) begin
      errors++; $display("[TB] FAIL held_first_accept: got no pulse expected one");
    end
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    checks++;
    if (bus.col !== 4'b1110 || bus.num !== BUF_BLANK) begin
      errors++; $display("[TB] FAIL held_reset_state: got col %b num %h expected 1110 %h", bus.col, bus.num, BUF_BLANK);
    end
    checks++;
    if (bus.key_code !== 5'd0 || bus.key_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL held_reset_key: got code %0d valid %b expected 0 0", bus.key_code, bus.key_valid);
    end
    got = 1'b0;
    for (int i = 0; i < PRESS_BOUND; i++) begin
      @(negedge clk);
      if (bus.key_valid) begin
        got = 1'b1;
        break;
      end
    end
    model_push(9);
    checks++;
    if (!got || bus.key_code !== 5'd9) begin
      errors++; $display("[TB] FAIL held_reaccept: got valid %b code %0d expected 1 9", got, bus.key_code);
    end
    checks++;
    if (bus.num !== model_num()) begin
      errors++; $display("[TB] FAIL held_reaccept_num: got %h expected %h", bus.num, model_num());
    end
    release_all();
  endtask

  initial begin
    bus.clr = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    test_reset();
    test_single_key();
    test_sequence();
    test_random_keys();
    test_glitch();
    test_two_rows();
    test_clr();
    test_reset_held();
    #1;
    checks++;
    if (double_pulse != 0) begin
      errors++; $display("[TB] FAIL pulse_width: got %0d multi-cycle pulses expected 0", double_pulse);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Input-side counterpart of the 7-segment display driver. Scans a 4x4 hex matrix keypad, debounces and decodes one key at a time into a 5-bit character code, and shifts accepted codes into a 20-bit, four-digit buffer. The buffer uses the display driver's character encoding (0–15 hex digits, 31 blank) and feeds its `num` input directly.

## Interface
- `SCAN_DIV`, default 25000: clk cycles per scan tick.
- `DEBOUNCE`, default 4: consecutive identical scan samples required to accept a press or a release (≥1).

- `clk`, in, 1: system clock.
- `rst_n`, in, 1: synchronous, active-low reset.
- `row`, in, 4: keypad rows, active-low, externally pulled up. Asynchronous to `clk`.
- `clr`, in, 1: synchronous clear of the digit buffer.
- `col`, out, 4: keypad column drive, active-low one-hot.
- `num`, out, 20: digit buffer, four 5-bit codes. `num[4:0]` is the newest digit.
- `key_code`, out, 5: code of the last accepted key.
- `key_valid`, out, 1: one-clk pulse when a key is accepted.

## Operation
- `row` passes through a 2-flop synchronizer before any use.
- Tick generator:
  - Counter runs 0..SCAN_DIV-1.
  - `tick` is high for one clk when the count is SCAN_DIV-1.
- Key mapping: the key at row r (`row[r]` low) and column c (`col[c]` low) decodes to code 4·r + c, range 0–15.
- FSM states: SCAN, DEBOUNCE, HELD, RELEASE. All transitions and samples happen only on `tick`.
- **SCAN**
  - Sample the synced rows.
  - All rows high: rotate `col` left by one (1110→1101→1011→0111→1110) and stay in SCAN.
  - Exactly one row low: latch row index and column index, deb_cnt←1, go to DEBOUNCE. `col` is held.
  - Two or more rows low: treated as bounce. Rotate and stay in SCAN.
- **DEBOUNCE**
  - Sample equals the latched pattern: increment deb_cnt.
  - When deb_cnt reaches DEBOUNCE: accept the key and go to HELD. With DEBOUNCE=1, accept occurs in the SCAN→DEBOUNCE tick itself.
  - Any other sample: rotate `col` and return to SCAN.
- **Accept** (single clk):
  - `key_code` ← code.
  - `key_valid` = 1.
  - `num` ← {num[14:0], code}.
- **HELD**
  - `col` is held.
  - Synced rows all high: deb_cnt←1, go to RELEASE.
  - Otherwise stay in HELD.
- **RELEASE**
  - Rows all high: increment deb_cnt. When it reaches DEBOUNCE, rotate `col` and go to SCAN.
  - Any row low: go back to HELD, with no new accept.
- **`clr`**
  - `num` ← 20'hFFFFF (four blanks) on the next edge.
  - If `clr` and accept coincide, `clr` wins on `num`. `key_valid` and `key_code` still update.
  - `clr` does not affect the FSM.
- Buffer overflow: the oldest digit (`num[19:15]`) is discarded on every shift. No saturation.

## Timing
- Reset values:
  - `col` = 4'b1110
  - `num` = 20'hFFFFF
  - `key_code` = 0
  - `key_valid` = 0
  - FSM = SCAN, tick counter = 0, deb_cnt = 0, synchronizer flops = 4'b1111
- Reset takes effect on the next edge, including mid-debounce or mid-hold. A key still held after reset is re-detected and accepted again once it has been debounced.
- Column dwell: SCAN_DIV clk per column. Rows are sampled at the end of each dwell, so each column is driven a full period before it is sampled.
- Press latency, from a stable press to the `key_valid` pulse: at most 2 clk (sync) + 4·SCAN_DIV (worst-case column wait) + (DEBOUNCE−1)·SCAN_DIV.
- `key_valid` lasts exactly 1 clk. `num` and `key_code` show the new values on the cycle after the accepting edge, and hold them until the next accept or `clr`.
- One accept per press. Auto-repeat is not supported.

## Structure
- Shared package `keypad_pkg` holds:
  - state enum {SCAN, DEBOUNCE, HELD, RELEASE}
  - `CODE_W` = 5
  - `BLANK` = 5'd31
  - `BUF_BLANK` = 20'hFFFFF
- Sub-module `scan_tick`: parameterized divider with a one-clk `tick` output and a synchronous active-low reset.
- Everything else lives in `keypad_entry`: synchronizer, FSM, debounce counter, digit buffer.

## Test plan
Bench settings: SCAN_DIV=4, DEBOUNCE=2.

1. Reset, then idle for 40 clk → `col` cycles 1110, 1101, 1011, 0111, changing every 4 clk; `num` = FFFFF; `key_valid` never asserts.
2. Hold key r=2, c=1 (row[2] low only while col[1] is low) → exactly one `key_valid` pulse; `key_code` = 9; `num` = {15'h7FFF, 5'd9}. Keep holding for 100 clk → no further pulses.
3. Press and release keys 1, 2, 3, 4, 5 in turn → `num` = {5'd2, 5'd3, 5'd4, 5'd5}, i.e. digit 1 shifted out.
4. Apply a row glitch lasting 1 tick, then drop it → no accept, FSM back in SCAN, `col` rotating again.
5. Press rows 0 and 1 together in the same column → no accept. Assert `clr` on the cycle of an accept → `num` = FFFFF and `key_valid` = 1.
6. Assert `rst_n` = 0 for 1 clk during HELD → all outputs return to their reset values on the next edge; the held key is accepted again after debounce.
